serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  - Bit-serial A - B - bin engine; LSB first, one bit per clock through a single full-subtractor cell.
//  - Performs the inverse arithmetic of the ripple adder.
//  - Used where area matters more than latency.
//  - Sits beside the adders in the arithmetic library. Start/done handshake to a controlling FSM.
// PARAMETERS
//  - WIDTH  4  operand/result width in bits (>=1)
// PORTS
//  - clk    in   1      single clock, rising edge
//  - rst_n  in   1      asynchronous, active-low reset
//  - start  in   1      request; sampled only in IDLE
//  - a      in   WIDTH  minuend; captured on accepted start
//  - b      in   WIDTH  subtrahend; captured on accepted start
//  - bin    in   1      borrow-in; captured on accepted start
//  - busy   out  1      high while state != IDLE
//  - done   out  1      one-cycle pulse; diff/bout valid from this cycle
//  - diff   out  WIDTH  result a-b-bin mod 2^WIDTH; held until next done
//  - bout   out  1      borrow-out (1 when a < b+bin, unsigned)
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, diff, bout = 0; internal shift registers and bit counter = 0.
//  - FSM states: IDLE -> RUN -> DONE -> IDLE.
//    - IDLE: start=1 latches a, b, bin into shift regs; cnt=0; go RUN.
//    - RUN: compute bit cnt, then shift. Exit to DONE when cnt == WIDTH-1.
//    - DONE: one cycle. done=1; copy result shift reg to diff and final borrow to bout.
//  - Bit cell, with x=a_i, y=b_i, w=borrow: d = x^y^w; w' = (~x&y) | (~(x^y)&w).
//  - Latency: start sampled at edge k.
//    - busy=1 from k+1 through k+WIDTH+1.
//    - done=1 for exactly the cycle after edge k+WIDTH+1.
//    - Next start accepted at edge k+WIDTH+2.
//  - start while busy (RUN or DONE) is ignored; inputs not re-captured; no queuing.
//  - a/b/bin may change freely after capture without effect.
//  - diff/bout change only on entry to DONE. Intermediate bits never visible on outputs.
//  - Counter width is $clog2(WIDTH)+1. WIDTH=1 gives a single RUN cycle.
//  - Reset mid-operation aborts immediately: all outputs to reset values; no done pulse.
// CONFIGURATION
//  - SERSUB_OVF_EN defined:
//    - Extra port `ovf out 1`, reset 0, updated with diff at DONE.
//    - ovf = two's-complement signed overflow = borrow into MSB XOR borrow out of MSB.
//  - SERSUB_OVF_EN undefined: no ovf port, no MSB borrow tap; otherwise identical.
// STRUCTURE
//  - Shared package arith_pkg:
//    - state typedef {IDLE, RUN, DONE} (2-bit encoding).
//    - localparam default width ARITH_W=4.
//  - Sub-module full_subtractor (x, y, bin -> d, bout): purely combinational.
//    - Instantiated once; FSM, counter and shift regs live in the top.
// TESTING
//  - WIDTH=4, a=9, b=3, bin=0 -> done at start+5 cycles; diff=4'h6, bout=0.
//  - a=3, b=9, bin=0 -> diff=4'hA, bout=1.
//  - a=0, b=0, bin=1 -> diff=4'hF, bout=1.
//  - a=4'hF, b=4'hF, bin=0 -> diff=0, bout=0.
//  - Hold start high for 10 cycles with a=5, b=2; change a to 1 at cycle 2.
//    - Exactly one done; diff=3; second op accepted at start+6.
//  - Assert rst_n=0 on the 2nd RUN cycle -> busy, done, diff, bout = 0; no done pulse.
//    - A new start then completes normally.
//  - SERSUB_OVF_EN: a=4'h8, b=4'h1 -> diff=4'h7, ovf=1; a=4'h7, b=4'h1 -> diff=6, ovf=0.
//  - WIDTH=1, a=0, b=1 -> diff=1, bout=1, done at start+2.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic-library package: serial FSM state encoding and default operand width.
package arith_pkg;

    localparam int ARITH_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, with borrow-out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first through one full_subtractor cell, start/done handshake.
// Optional signed-overflow output is enabled by defining SERSUB_OVF_EN.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] r_sh_q, r_sh_d;
    logic             w_q, w_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             done_q, done_d;
`ifdef SERSUB_OVF_EN
    logic             msb_bin_q, msb_bin_d;
    logic             ovf_q, ovf_d;
`endif

    logic cell_d;
    logic cell_bout;

    full_subtractor u_cell (
        .x    (a_sh_q[0]),
        .y    (b_sh_q[0]),
        .bin  (w_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        r_sh_d  = r_sh_q;
        w_d     = w_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        done_d  = 1'b0;
`ifdef SERSUB_OVF_EN
        msb_bin_d = msb_bin_q;
        ovf_d     = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    w_d     = bin;
                    r_sh_d  = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                r_sh_d = (r_sh_q >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));
                w_d    = cell_bout;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
`ifdef SERSUB_OVF_EN
                    msb_bin_d = w_q;
`endif
                end
            end
            DONE: begin
                done_d  = 1'b1;
                diff_d  = r_sh_q;
                bout_d  = w_q;
`ifdef SERSUB_OVF_EN
                ovf_d   = msb_bin_q ^ w_q;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            w_q     <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERSUB_OVF_EN
            msb_bin_q <= 1'b0;
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            r_sh_q  <= r_sh_d;
            w_q     <= w_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            done_q  <= done_d;
`ifdef SERSUB_OVF_EN
            msb_bin_q <= msb_bin_d;
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SERSUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=4 and WIDTH=1 (define SERSUB_OVF_EN to cover ovf).
module tb_serial_subtractor;

    typedef struct {
        logic [3:0] diff;
        logic       bout;
        logic       ovf;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       bin = 1'b0;
    logic       busy, done, bout;
    logic [3:0] diff;
    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       bin1 = 1'b0;
    logic       busy1, done1, bout1;
    logic [0:0] diff1;
`ifdef SERSUB_OVF_EN
    logic       ovf, ovf1;
`endif

    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t q4[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_subtractor #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout)
`ifdef SERSUB_OVF_EN
        , .ovf(ovf)
`endif
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
`ifdef SERSUB_OVF_EN
        , .ovf(ovf1)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q4.size() == 0) begin
                chk("w4_unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q4.pop_front();
                chk("w4_diff", {28'd0, diff}, {28'd0, e.diff});
                chk("w4_bout", {31'd0, bout}, {31'd0, e.bout});
                chk("w4_done_cycle", cyc, e.cyc);
`ifdef SERSUB_OVF_EN
                chk("w4_ovf", {31'd0, ovf}, {31'd0, e.ovf});
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                chk("w1_unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("w1_diff", {31'd0, diff1}, {28'd0, e.diff});
                chk("w1_bout", {31'd0, bout1}, {31'd0, e.bout});
                chk("w1_done_cycle", cyc, e.cyc);
`ifdef SERSUB_OVF_EN
                chk("w1_ovf", {31'd0, ovf1}, {31'd0, e.ovf});
`endif
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 30 && (q4.size() != 0 || q1.size() != 0); i++) @(negedge clk);
        chk("drain_w4", q4.size(), 0);
        chk("drain_w1", q1.size(), 0);
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic run_op(input logic [3:0] ai, input logic [3:0] bi, input logic bini,
                          input logic [3:0] ed, input logic eb, input logic eo);
        exp_t e;
        @(negedge clk);
        a = ai; b = bi; bin = bini; start = 1'b1;
        e.diff = ed; e.bout = eb; e.ovf = eo; e.cyc = cyc + 6;
        q4.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = ~ai; b = ~bi; bin = ~bini;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        drain();
    endtask

    initial begin
        exp_t e;
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_diff", {28'd0, diff}, 32'd0);
        chk("rst_bout", {31'd0, bout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(4'd9, 4'd3, 1'b0, 4'h6, 1'b0, 1'b0);
        run_op(4'd3, 4'd9, 1'b0, 4'hA, 1'b1, 1'b0);
        run_op(4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0);
        run_op(4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0);
        run_op(4'h8, 4'h1, 1'b0, 4'h7, 1'b0, 1'b1);
        run_op(4'h7, 4'h1, 1'b0, 4'h6, 1'b0, 1'b0);

        // start held for 10 edges; a drops to 1 before the third edge.
        @(negedge clk);
        a = 4'd5; b = 4'd2; bin = 1'b0; start = 1'b1;
        e.diff = 4'h3; e.bout = 1'b0; e.ovf = 1'b0; e.cyc = cyc + 6;
        q4.push_back(e);
        e.diff = 4'hF; e.bout = 1'b1; e.ovf = 1'b0; e.cyc = cyc + 12;
        q4.push_back(e);
        for (int i = 0; i < 10; i++) begin
            if (i == 2) a = 4'd1;
            @(negedge clk);
        end
        start = 1'b0;
        drain();

        // Reset during the second RUN cycle.
        @(negedge clk);
        a = 4'd9; b = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_diff", {28'd0, diff}, 32'd0);
        chk("abort_bout", {31'd0, bout}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        run_op(4'd9, 4'd3, 1'b0, 4'h6, 1'b0, 1'b0);

        // WIDTH=1 instance.
        @(negedge clk);
        a1 = 1'b0; b1 = 1'b1; bin1 = 1'b0; start1 = 1'b1;
        e.diff = 4'h1; e.bout = 1'b1; e.ovf = 1'b1; e.cyc = cyc + 3;
        q1.push_back(e);
        @(negedge clk);
        start1 = 1'b0;
        chk("w1_busy", {31'd0, busy1}, 32'd1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
        $fatal(1, "timeout");
    end

endmodule
